bus_rr_arbiter: RTL and testbench

Round-robin bus arbiter for the four-master shared system bus. It accepts the active-low request lines of bus masters 0–3 (IF stage, MEM stage, two reserved slots), grants ownership to exactly one master at a time, and drives the owner index consumed by the bus master multiplexer. The current owner keeps the bus for as long as it holds its request. An optional hold watchdog bounds how long one master may keep the bus while others wait.

---
 rtl/bus_rr_arbiter.sv | 263 ++++++++++++++++++++++++++
 tb/tb_bus_rr_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// bus_rr_arbiter
//
// Round-robin arbiter for the four-master shared system bus (master 0 = IF
// stage, master 1 = MEM stage, masters 2/3 = reserved slots). Exactly one
// master owns the bus at a time. The owner keeps the bus for as long as it
// holds its request. When it releases, the next requester in rotation order
// takes over at the same clock edge, so there is no dead cycle between owners.
//
// Optional feature macro: ARB_WATCHDOG_EN
//   Defined   : an 8-bit hold counter limits how long one owner may keep the
//               bus while other masters wait. When the limit is reached and
//               another request is pending, the grant is forcibly handed on
//               and hold_timeout pulses for one cycle.
//   Undefined : no counter is built, hold_timeout is constant low, and an
//               owner may hold the bus indefinitely.
//
// Parameters
//   HOLD_MAX      watchdog hold limit in cycles, 1..255 (watchdog builds only)
//
// Ports
//   clk           clock, single domain
//   reset         synchronous active-high reset
//   m0_req_..m3_req_    bus requests, active low
//   m0_grnt_..m3_grnt_  bus grants, active low, registered, at most one low
//   owner         index of the current or most recent owner, registered;
//                 also serves as the rotation pointer while idle
//   busy          high while any grant is asserted, registered
//   hold_timeout  one-cycle pulse in the first cycle of a forced handover
// -----------------------------------------------------------------------------
module bus_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req_,
  input  logic       m1_req_,
  input  logic       m2_req_,
  input  logic       m3_req_,
  output logic       m0_grnt_,
  output logic       m1_grnt_,
  output logic       m2_grnt_,
  output logic       m3_grnt_,
  output logic [1:0] owner,
  output logic       busy,
  output logic       hold_timeout
);

  // ---------------------------------------------------------------------------
  // Parameter sanity: the counter is 8 bits and a zero limit would revoke a
  // grant before the owner could use the bus at all.
  // ---------------------------------------------------------------------------
  if ((HOLD_MAX < 1) || (HOLD_MAX > 255)) begin : g_bad_hold_max
    $error("bus_rr_arbiter: HOLD_MAX must be in the range 1..255");
  end

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  logic [0:0] state_q,        state_d;
  logic [1:0] owner_q,        owner_d;
  logic [3:0] grnt_q,         grnt_d;          // active-high, one-hot or zero
  logic       busy_q,         busy_d;
  logic       hold_timeout_q, hold_timeout_d;

  // ---------------------------------------------------------------------------
  // Request decode (internally everything is active high)
  // ---------------------------------------------------------------------------
  logic [3:0] req_vec;
  logic [3:0] owner_mask;       // one-hot decode of owner_q
  logic [3:0] others_vec;       // requests from everyone except the owner
  logic       any_req;
  logic       owner_req;
  logic       others_pending;
  logic       wd_revoke;        // watchdog demands a forced handover

  assign req_vec = ~{m3_req_, m2_req_, m1_req_, m0_req_};

  for (genvar gi = 0; gi < 4; gi++) begin : g_owner_dec
    assign owner_mask[gi] = (owner_q == 2'(gi));
  end

  assign others_vec     = req_vec & ~owner_mask;
  assign any_req        = |req_vec;
  assign owner_req      = |(req_vec & owner_mask);
  assign others_pending = |others_vec;

  // ---------------------------------------------------------------------------
  // Round-robin pick: search last+1, last+2, last+3, last (mod 4) and return
  // the first requester found. The most recent owner is therefore always the
  // lowest-priority candidate. Callers only use the result when req is
  // non-zero, so the "nothing found" return value is irrelevant.
  // ---------------------------------------------------------------------------
  function automatic logic [1:0] rr_pick(input logic [3:0] req,
                                         input logic [1:0] last);
    logic [1:0] pick;
    logic [1:0] cand;
    logic       found;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last + 2'(i);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // ---------------------------------------------------------------------------
  // Hold watchdog
  // ---------------------------------------------------------------------------
`ifdef ARB_WATCHDOG_EN
  localparam logic [7:0] HOLD_LIMIT = 8'(HOLD_MAX);

  logic [7:0] hold_cnt_q, hold_cnt_d;

  // The limit is only enforced when someone else is actually waiting; a lone
  // owner simply saturates the counter and keeps the bus.
  assign wd_revoke = (state_q == ST_GRANT) && owner_req && others_pending &&
                     (hold_cnt_q == HOLD_LIMIT);

  // The counter measures consecutive held cycles of the current owner. Any
  // grant change (new grant from idle, voluntary handover, forced handover,
  // release to idle) restarts it from zero.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if ((state_q != ST_GRANT) || !owner_req || wd_revoke) begin
      hold_cnt_d = 8'd0;
    end else if (hold_cnt_q != HOLD_LIMIT) begin
      hold_cnt_d = hold_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt_q <= 8'd0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  assign wd_revoke = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [1:0] winner;

    state_d        = state_q;
    owner_d        = owner_q;
    grnt_d         = grnt_q;
    busy_d         = busy_q;
    hold_timeout_d = 1'b0;
    winner         = owner_q;

    case (state_q)
      ST_IDLE: begin
        grnt_d = 4'b0000;
        busy_d = 1'b0;
        if (any_req) begin
          // owner_q still holds the most recent owner, so the rotation
          // continues where it left off before the idle period.
          winner  = rr_pick(req_vec, owner_q);
          owner_d = winner;
          grnt_d  = onehot4(winner);
          busy_d  = 1'b1;
          state_d = ST_GRANT;
        end
      end

      ST_GRANT: begin
        if (owner_req) begin
          // Owner keeps the bus unless the watchdog has expired with other
          // masters waiting; then the bus moves on exactly as if the owner
          // had released it.
          if (wd_revoke) begin
            winner         = rr_pick(others_vec, owner_q);
            owner_d        = winner;
            grnt_d         = onehot4(winner);
            hold_timeout_d = 1'b1;
          end
        end else if (others_pending) begin
          // Direct handover in the same edge: no idle cycle between owners.
          winner  = rr_pick(others_vec, owner_q);
          owner_d = winner;
          grnt_d  = onehot4(winner);
        end else begin
          // Nobody wants the bus. owner_q is left alone as rotation pointer.
          grnt_d  = 4'b0000;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        grnt_d  = 4'b0000;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers. Reset puts owner at 3 so that master 0 is the first
  // candidate in the search after reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      owner_q        <= 2'd3;
      grnt_q         <= 4'b0000;
      busy_q         <= 1'b0;
      hold_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      grnt_q         <= grnt_d;
      busy_q         <= busy_d;
      hold_timeout_q <= hold_timeout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all straight from flops)
  // ---------------------------------------------------------------------------
  assign {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_} = ~grnt_q;
  assign owner        = owner_q;
  assign busy         = busy_q;
  assign hold_timeout = hold_timeout_q;

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
  a_grant_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(grnt_q));

  a_busy_matches_grant: assert property (@(posedge clk) disable iff (reset)
    busy_q == (grnt_q != 4'b0000));

  a_grant_matches_owner: assert property (@(posedge clk) disable iff (reset)
    (grnt_q != 4'b0000) |-> (grnt_q == onehot4(owner_q)));

  // A grant can only appear for a master that was requesting at that edge.
  for (genvar gi = 0; gi < 4; gi++) begin : g_grant_chk
    a_grant_needs_req: assert property (@(posedge clk) disable iff (reset)
      (grnt_q[gi] && !$past(grnt_q[gi])) |-> $past(req_vec[gi]));
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_rr_arbiter
//
// Self-checking bench for bus_rr_arbiter:
//   1. a table of single-cycle vectors {reset, req_n} -> {grnt_n, owner, busy}
//      covering reset priority, rotation, hold/idle, pointer after idle and
//      reset during ownership;
//   2. a hand-written long-hold sequence (forced handover in watchdog builds,
//      indefinite hold otherwise);
//   3. randomized requests and resets checked against a cycle-level
//      reference model of the arbitration rules.
// Inputs change 1 time unit after each rising edge; outputs are sampled at
// that same point, before the new inputs are applied.
// -----------------------------------------------------------------------------
module tb_bus_rr_arbiter;

  localparam int TB_HOLD = 4;
`ifdef ARB_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       m0_req_, m1_req_, m2_req_, m3_req_;
  logic       m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
  logic [1:0] owner;
  logic       busy;
  logic       hold_timeout;

  always #5 clk = ~clk;

  bus_rr_arbiter #(.HOLD_MAX(TB_HOLD)) dut (
    .clk          (clk),
    .reset        (reset),
    .m0_req_      (m0_req_),
    .m1_req_      (m1_req_),
    .m2_req_      (m2_req_),
    .m3_req_      (m3_req_),
    .m0_grnt_     (m0_grnt_),
    .m1_grnt_     (m1_grnt_),
    .m2_grnt_     (m2_grnt_),
    .m3_grnt_     (m3_grnt_),
    .owner        (owner),
    .busy         (busy),
    .hold_timeout (hold_timeout)
  );

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit rst, input logic [3:0] req_n);
    reset = rst;
    {m3_req_, m2_req_, m1_req_, m0_req_} = req_n;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int grnt_n_vec();
    return int'({m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_});
  endfunction

  task automatic check_outputs(input string tag, input logic [3:0] exp_grnt_n,
                               input int exp_owner, input bit exp_busy,
                               input bit exp_to);
    check($sformatf("%s grnt_n", tag), grnt_n_vec(), int'(exp_grnt_n));
    check($sformatf("%s owner", tag), int'(owner), exp_owner);
    check($sformatf("%s busy", tag), int'(busy), int'(exp_busy));
    check($sformatf("%s hold_timeout", tag), int'(hold_timeout), int'(exp_to));
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: who owns the bus, expressed with plain integers.
  // mdl_owner is -1-free: it always holds the current or last owner index.
  // ---------------------------------------------------------------------------
  bit mdl_busy;
  int mdl_owner;
  bit mdl_to;
  int mdl_held;     // consecutive held cycles of the current owner

  // First requester after 'from' going upward with wrap, skipping 'skip'.
  function automatic int next_in_rotation(input bit want[4], input int from,
                                          input int skip);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (from + k) % 4;
      if (c != skip && want[c]) return c;
    end
    return from;
  endfunction

  task automatic model_step(input bit rst, input logic [3:0] req_n);
    bit want[4];
    int n_want;
    int n_others;
    n_want = 0;
    for (int i = 0; i < 4; i++) begin
      want[i] = !req_n[i];
      if (want[i]) n_want++;
    end
    mdl_to = 1'b0;
    if (rst) begin
      mdl_busy  = 1'b0;
      mdl_owner = 3;
      mdl_held  = 0;
    end else if (!mdl_busy) begin
      if (n_want > 0) begin
        mdl_owner = next_in_rotation(want, mdl_owner, -1);
        mdl_busy  = 1'b1;
        mdl_held  = 0;
      end
    end else if (want[mdl_owner]) begin
      n_others = n_want - 1;
      if (WD_EN && mdl_held == TB_HOLD && n_others > 0) begin
        mdl_owner = next_in_rotation(want, mdl_owner, mdl_owner);
        mdl_to    = 1'b1;
        mdl_held  = 0;
      end else if (mdl_held < TB_HOLD) begin
        mdl_held++;
      end
    end else if (n_want > 0) begin
      mdl_owner = next_in_rotation(want, mdl_owner, mdl_owner);
      mdl_held  = 0;
    end else begin
      mdl_busy = 1'b0;
      mdl_held = 0;
    end
  endtask

  task automatic check_model(input string tag);
    logic [3:0] exp_grnt_n;
    exp_grnt_n = 4'b1111;
    if (mdl_busy) exp_grnt_n[mdl_owner] = 1'b0;
    check_outputs(tag, exp_grnt_n, mdl_owner, mdl_busy, mdl_to);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table. req_n / grnt_n are {m3, m2, m1, m0}, active low.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit         rst;
    logic [3:0] req_n;
    logic [3:0] grnt_n;
    int         owner;
    bit         busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rst, input logic [3:0] req_n,
                     input logic [3:0] grnt_n, input int own, input bit bsy);
    vec_t v;
    v.rst    = rst;
    v.req_n  = req_n;
    v.grnt_n = grnt_n;
    v.owner  = own;
    v.busy   = bsy;
    vecs.push_back(v);
  endtask

  initial begin
    logic [3:0] rq;
    bit         rst;

    drive(1'b1, 4'b1111);

    // Reset state, then all four request together: master 0 wins.
    add(1, 4'b1111, 4'b1111, 3, 0);
    add(0, 4'b0000, 4'b1110, 0, 1);
    // Rotation: each owner holds 3 cycles, releases for one cycle.
    add(0, 4'b0000, 4'b1110, 0, 1);
    add(0, 4'b0000, 4'b1110, 0, 1);
    add(0, 4'b0001, 4'b1101, 1, 1);
    add(0, 4'b0000, 4'b1101, 1, 1);
    add(0, 4'b0000, 4'b1101, 1, 1);
    add(0, 4'b0010, 4'b1011, 2, 1);
    add(0, 4'b0000, 4'b1011, 2, 1);
    add(0, 4'b0000, 4'b1011, 2, 1);
    add(0, 4'b0100, 4'b0111, 3, 1);
    add(0, 4'b0000, 4'b0111, 3, 1);
    add(0, 4'b0000, 4'b0111, 3, 1);
    add(0, 4'b1000, 4'b1110, 0, 1);
    // Everyone drops: back to idle, owner remembered.
    add(0, 4'b1111, 4'b1111, 0, 0);
    // Hold and idle: only m1 for 10 cycles, then release.
    for (int i = 0; i < 10; i++) add(0, 4'b1101, 4'b1101, 1, 1);
    add(0, 4'b1111, 4'b1111, 1, 0);
    // Pointer after idle: m0 and m2 together, search starts at 2.
    add(0, 4'b1010, 4'b1011, 2, 1);
    // Reset while m2 owns with request still low, then re-grant.
    add(0, 4'b1011, 4'b1011, 2, 1);
    add(1, 4'b1011, 4'b1111, 3, 0);
    add(0, 4'b1011, 4'b1011, 2, 1);
    add(0, 4'b1111, 4'b1111, 2, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].req_n);
      tick();
      check_outputs($sformatf("vec%0d", i), vecs[i].grnt_n, vecs[i].owner,
                    vecs[i].busy, 1'b0);
      $display("vec %0d: rst=%0b req_n=%b -> grnt_n=%b owner=%0d busy=%0b",
               i, vecs[i].rst, vecs[i].req_n, grnt_n_vec(), owner, busy);
    end

    // -------------------------------------------------------------------------
    // Long hold by m0 while m3 waits.
    // -------------------------------------------------------------------------
    drive(1'b1, 4'b1111);
    tick();
    check_outputs("hold reset", 4'b1111, 3, 1'b0, 1'b0);
    drive(1'b0, 4'b1110);
    tick();
    check_outputs("hold grant m0", 4'b1110, 0, 1'b1, 1'b0);
    drive(1'b0, 4'b0110);
`ifdef ARB_WATCHDOG_EN
    for (int i = 1; i <= TB_HOLD; i++) begin
      tick();
      check_outputs($sformatf("wd hold%0d", i), 4'b1110, 0, 1'b1, 1'b0);
    end
    tick();
    check_outputs("wd revoke", 4'b0111, 3, 1'b1, 1'b1);
    $display("watchdog: forced handover to m3, hold_timeout=%0b", hold_timeout);
    tick();
    check_outputs("wd after", 4'b0111, 3, 1'b1, 1'b0);
`else
    for (int i = 1; i <= 120; i++) begin
      tick();
      check_outputs($sformatf("nowd hold%0d", i), 4'b1110, 0, 1'b1, 1'b0);
    end
    $display("no watchdog: m0 held the bus for 120 cycles, owner=%0d", owner);
    drive(1'b0, 4'b0111);
    tick();
    check_outputs("nowd handover", 4'b0111, 3, 1'b1, 1'b0);
`endif

    // -------------------------------------------------------------------------
    // Randomized requests against the reference model.
    // -------------------------------------------------------------------------
    rq = 4'b1111;
    drive(1'b1, rq);
    tick();
    model_step(1'b1, rq);
    check_model("rand reset");
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 3) == 0) rq[i] = ~rq[i];
      end
      drive(rst, rq);
      tick();
      model_step(rst, rq);
      check_model($sformatf("rand%0d", c));
      if (c % 250 == 0)
        $display("rand %0d: rst=%0b req_n=%b -> grnt_n=%b owner=%0d busy=%0b to=%0b",
                 c, rst, rq, grnt_n_vec(), owner, busy, hold_timeout);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
